// File: rtl/serial_to_parallel_rx_if.sv
// Serial link receive interface.
// Bundles the 1-bit serial input with the deserialized byte outputs.
//   data_in      serial bit, MSB of each symbol first (driven by the link source)
//   data_out     last received data byte
//   valid_out    data_out holds a valid data byte
//   idle_out     last symbol while active was a comma or idle character
//   active       link locked and aligned
//   byte_strobe  1-cycle pulse on each symbol boundary while active
// master: the side that drives the serial stream and consumes the bytes.
// slave:  the receiver.
interface serial_to_parallel_rx_if #(
  parameter int WIDTH = 8
) ();
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             idle_out;
  logic             active;
  logic             byte_strobe;

  modport master (
    output data_in,
    input  data_out, valid_out, idle_out, active, byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, idle_out, active, byte_strobe
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver.
// Shifts in a 1-bit MSB-first stream on clk_32f, aligns to the comma character,
// declares the link active after LOCK_COUNT consecutive aligned commas, then
// delivers data bytes (valid_out) and flags idle/comma symbols (idle_out).
// Ports:
//   clk_32f  bit clock, one serial bit per rising edge
//   reset    synchronous, active-low (0 = reset)
//   link     serial_to_parallel_rx_if slave modport (data_in in; data_out,
//            valid_out, idle_out, active, byte_strobe out)
module serial_to_parallel_rx #(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA    = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE_CODE = 8'h7C,
  parameter int             LOCK_COUNT = 4
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  serial_to_parallel_rx_if.slave link
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CC_W  = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             idl_q, idl_d;
  logic             act_q, act_d;
  logic             stb_q, stb_d;

  // Symbol completing at this edge: the shift register plus the incoming bit.
  logic [WIDTH-1:0] win;
  logic             boundary;

  assign win      = {sr_q[WIDTH-2:0], link.data_in};
  assign boundary = (bit_cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    sr_d        = win;
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + CNT_W'(1);
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    vld_d       = vld_q;
    idl_d       = idl_q;
    act_d       = act_q;
    stb_d       = 1'b0;

    case (state_q)
      SEARCH: begin
        // Bit-level hunt: the comma fixes the phase, so the next edge is bit 0.
        if (win == COMMA) begin
          bit_cnt_d   = '0;
          comma_cnt_d = CC_W'(1);
          if (LOCK_COUNT == 1) begin
            state_d = ACTIVE;
            act_d   = 1'b1;
            idl_d   = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end

      COUNT: begin
        if (boundary) begin
          if (win == COMMA) begin
            if (comma_cnt_q == CC_W'(LOCK_COUNT - 1)) begin
              comma_cnt_d = CC_W'(LOCK_COUNT);
              state_d     = ACTIVE;
              act_d       = 1'b1;
              // The locking comma is reported as an idle symbol.
              idl_d       = 1'b1;
            end else begin
              comma_cnt_d = comma_cnt_q + CC_W'(1);
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Alignment is frozen; commas straddling boundaries are never seen.
        if (boundary) begin
          stb_d = 1'b1;
          if ((win == COMMA) || (win == IDLE_CODE)) begin
            vld_d = 1'b0;
            idl_d = 1'b1;
          end else begin
            data_d = win;
            vld_d  = 1'b1;
            idl_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Register stage: everything visible the cycle after the sampling edge.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      idl_q       <= 1'b0;
      act_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      idl_q       <= idl_d;
      act_q       <= act_d;
      stb_q       <= stb_d;
    end
  end

  assign link.data_out    = data_q;
  assign link.valid_out   = vld_q;
  assign link.idle_out    = idl_q;
  assign link.active      = act_q;
  assign link.byte_strobe = stb_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Testbench for serial_to_parallel_rx: symbol table with hand-computed
// expectations, hand-written reset/relock sequences, and a randomized stream
// compared edge by edge against a stream-level reference model.
module tb_serial_to_parallel_rx;

  localparam int         W    = 8;
  localparam int         LOCK = 4;
  localparam logic [7:0] BC   = 8'hBC;
  localparam logic [7:0] IDL  = 8'h7C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_to_parallel_rx_if #(.WIDTH(W)) link ();

  serial_to_parallel_rx #(
    .WIDTH(W), .COMMA(BC), .IDLE_CODE(IDL), .LOCK_COUNT(LOCK)
  ) dut (
    .clk_32f (clk),
    .reset   (rst_n),
    .link    (link)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: tracks the edge index since reset, the edge where the
  // alignment comma was found, and how many aligned commas have been seen.
  logic [7:0] m_win = '0;
  bit         m_found = 0, m_active = 0;
  int         m_run = 0, m_anchor = 0, m_n = 0;
  logic [7:0] m_dat = '0;
  bit         m_vld = 0, m_idl = 0, m_stb = 0;

  task automatic model_step(input bit r, input bit b);
    logic [7:0] w;
    if (!r) begin
      m_win = '0; m_found = 0; m_active = 0; m_run = 0; m_anchor = 0; m_n = 0;
      m_dat = '0; m_vld = 0; m_idl = 0; m_stb = 0;
    end else begin
      w = {m_win[6:0], b};
      m_win = w;
      m_n++;
      m_stb = 0;
      if (m_active) begin
        if ((m_n - m_anchor) % W == 0) begin
          m_stb = 1;
          if (w == BC || w == IDL) begin
            m_vld = 0; m_idl = 1;
          end else begin
            m_dat = w; m_vld = 1; m_idl = 0;
          end
        end
      end else if (m_found) begin
        if ((m_n - m_anchor) % W == 0) begin
          if (w == BC) begin
            m_run++;
            if (m_run == LOCK) begin m_active = 1; m_idl = 1; end
          end else begin
            m_found = 0; m_run = 0;
          end
        end
      end else if (w == BC) begin
        m_found = 1; m_anchor = m_n; m_run = 1;
        if (m_run == LOCK) begin m_active = 1; m_idl = 1; end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_data_out",    32'(link.data_out),    32'(m_dat));
    check("model_valid_out",   32'(link.valid_out),   32'(m_vld));
    check("model_idle_out",    32'(link.idle_out),    32'(m_idl));
    check("model_active",      32'(link.active),      32'(m_active));
    check("model_byte_strobe", 32'(link.byte_strobe), 32'(m_stb));
  endtask

  // One bit clock: drive, clock, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit b);
    rst_n = r;
    link.data_in = b;
    @(posedge clk);
    #1;
    model_step(r, b);
    check_model();
  endtask

  task automatic send_byte(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) step(1'b1, s[i]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},    32'(link.data_out),    32'h0);
    check({tag, "_valid_out"},   32'(link.valid_out),   32'h0);
    check({tag, "_idle_out"},    32'(link.idle_out),    32'h0);
    check({tag, "_active"},      32'(link.active),      32'h0);
    check({tag, "_byte_strobe"}, 32'(link.byte_strobe), 32'h0);
  endtask

  typedef struct {
    bit         rst_first;
    logic [7:0] sym;
    bit         e_act, e_vld, e_idl, e_stb;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    link.data_in = 1'b0;

    tbl[0]  = '{1'b1, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, BC,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55};
    tbl[5]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[6]  = '{1'b0, IDL,   1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[7]  = '{1'b0, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0B};
    tbl[8]  = '{1'b0, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC0};
    tbl[9]  = '{1'b1, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, BC,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, BC,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset with random data, then a stream that never holds three ones in a
    // row and so can never form a comma.
    do_reset(3);
    check_all_zero("reset");
    for (int i = 0; i < 40; i++)
      step(1'b1, (i % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
    check("no_lock_active", 32'(link.active), 32'h0);

    // Symbol table: lock, data/idle delivery, straddling comma, failed lock.
    for (int v = 0; v < 17; v++) begin
      if (tbl[v].rst_first) begin
        do_reset(3);
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
      end
      send_byte(tbl[v].sym);
      check($sformatf("tbl%0d_active", v),      32'(link.active),      32'(tbl[v].e_act));
      check($sformatf("tbl%0d_valid_out", v),   32'(link.valid_out),   32'(tbl[v].e_vld));
      check($sformatf("tbl%0d_idle_out", v),    32'(link.idle_out),    32'(tbl[v].e_idl));
      check($sformatf("tbl%0d_byte_strobe", v), 32'(link.byte_strobe), 32'(tbl[v].e_stb));
      check($sformatf("tbl%0d_data_out", v),    32'(link.data_out),    32'(tbl[v].e_dat));
    end

    // Mid-symbol reset while active: clears at once, relock needs 4 commas.
    send_byte(8'h33);
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_all_zero("midreset");
    for (int k = 0; k < 3; k++) begin
      send_byte(BC);
      check($sformatf("relock%0d_active", k), 32'(link.active), 32'h0);
    end
    send_byte(BC);
    check("relock_active", 32'(link.active), 32'h1);
    check("relock_idle",   32'(link.idle_out), 32'h1);
    send_byte(8'h9D);
    check("relock_data",   32'(link.data_out), 32'h9D);
    check("relock_valid",  32'(link.valid_out), 32'h1);

    // Randomized stream against the model, with a slip and a mid-run reset.
    do_reset(2);
    for (int j = 0; j < 3; j++) step(1'b1, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 300; k++) begin
      logic [7:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (k < 6 || (k >= 160 && k < 166)) s = BC;
      else if (r == 0) s = BC;
      else if (r == 1) s = IDL;
      else s = 8'($urandom);
      if (k == 100) step(1'b1, 1'($urandom_range(0, 1)));
      if (k == 155) begin
        step(1'b1, 1'b1);
        do_reset(1);
      end
      send_byte(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
